gif_frame_sequencer: RTL and testbench
======================================

Name: gif_frame_sequencer

Overview:
Hardware sequencer that owns the read side of the 4x16 image-details on-chip RAM in the GIF player SoC. On start it fetches the four detail words (width, height, frame count, per-frame delay), validates them and publishes them as a configuration. It then paces playback: it waits the programmed delay, requests each frame from the decoder over a req/ack handshake, and wraps at the last frame.

Parameters:
TICK_DIV, 50000, clk cycles per delay tick (1 ms at 50 MHz); legal range 2..2^20.
DLY_W, 16, width of the delay word and delay counter.

Ports:
clk  in  1  system clock; all logic rising-edge.
reset  in  1  asynchronous, active-high; clears all state.
start  in  1  pulse; honoured only in IDLE.
stop  in  1  level/pulse; returns to IDLE from any state.
mem_address  out  2  image-details RAM word address.
mem_chipselect  out  1  RAM select, read-only use; write is tied low externally.
mem_readdata  in  16  RAM data; valid 1 cycle after address is presented (registered address, unregistered q).
cfg_valid  out  1  high while latched details are valid (CHECK passed and not in IDLE/ERROR).
img_width  out  16  latched word 0.
img_height  out  16  latched word 1.
frame_count  out  16  latched word 2.
frame_delay  out  16  latched word 3, in ticks.
frame_index  out  16  index of current/requested frame.
frame_req  out  1  request decoder to present frame_index.
frame_ack  in  1  decoder accepted frame; sampled only while frame_req is high.
loop_done  out  1  one-cycle pulse when index wraps from frame_count-1 to 0.
error  out  1  sticky until next start; set on invalid details.

Behaviour:
- Reset values: all outputs 0; state IDLE; prescaler and delay counter 0.
- States: IDLE, LOAD, CHECK, WAIT, REQ, ERROR.
- IDLE: start=1 -> LOAD; clears error, frame_index, cfg_valid.
- LOAD: mem_chipselect=1; mem_address = 0,1,2,3 on consecutive cycles (cycles L0..L3); word k is captured at cycle L(k+1); after capture of word 3 -> CHECK. LOAD spans exactly 5 cycles; chipselect is high for cycles L0..L3 only.
- CHECK (1 cycle): width, height or frame_count == 0 -> ERROR with error=1. Otherwise -> REQ (frame 0 is requested immediately with no delay), cfg_valid=1.
- REQ: frame_req=1, held until frame_ack=1 in the same cycle.
  - On ack: frame_req drops next cycle and the state goes to WAIT.
  - On ack, frame_index increments; if frame_index == frame_count-1 it becomes 0 instead and loop_done pulses in the same cycle as the index update.
- WAIT: the prescaler counts 0..TICK_DIV-1 and the delay counter increments on each wrap. When the delay counter reaches max(frame_delay,1) -> REQ, and both counters clear. A delay of 0 is treated as 1 tick.
- ERROR: hold; only stop (-> IDLE) or reset exits.
- stop has priority over every transition: next state IDLE, frame_req=0, cfg_valid=0. Latched detail outputs keep their values; frame_index clears.
- start while not IDLE: ignored. start and stop in the same cycle in IDLE: stop wins (stay IDLE).
- Asynchronous reset mid-LOAD or mid-REQ: immediate return to reset values; no partial configuration is published.
- Arithmetic: unsigned 16-bit; frame_index compare uses frame_count-1, computed in CHECK (count >= 1 is guaranteed).

Decomposition:
- Shared package gif_seq_pkg: state enum; detail word-offset constants (ADDR_WIDTH=0, ADDR_HEIGHT=1, ADDR_COUNT=2, ADDR_DELAY=3).
- One natural sub-module: gif_tick_prescaler, carrying TICK_DIV, clear and enable inputs, and a tick pulse output.
- FSM, loader and frame counter stay in the top module.

Test Plan:
- RAM preloaded {100, 80, 3, 2}, TICK_DIV=4, decoder acks 1 cycle after each req -> LOAD lasts 5 cycles with addresses 0..3; cfg_valid=1 and img_width=100, img_height=80; frame 0 requested with no delay; subsequent reqs spaced 2x4 cycles plus handshake; frame_index sequence 0,1,2,0; loop_done pulses once per wrap.
- RAM {100, 0, 3, 2} -> after CHECK, error=1, cfg_valid=0, no frame_req. stop -> IDLE; a subsequent start clears error.
- frame_delay=0, TICK_DIV=4 -> spacing equals the 1-tick case (4 cycles between ack and next req).
- Decoder withholds frame_ack for 20 cycles -> frame_req stays high and frame_index is stable; the delay counter does not run.
- stop asserted mid-WAIT and again mid-REQ -> IDLE next cycle, frame_req=0, frame_index=0; start while REQ is active is ignored.
- Async reset asserted in cycle L2 of LOAD -> all outputs 0 immediately; re-start reloads all four words correctly.

Source files
------------

// File: rtl/gif_seq_pkg.sv
// Shared definitions for the GIF frame sequencer.
// - Sequencer state encoding.
// - Word offsets of the four detail words in the 4x16 image-details RAM.
package gif_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_CHECK = 3'd2,
      ST_WAIT  = 3'd3,
      ST_REQ   = 3'd4,
      ST_ERROR = 3'd5
   } seq_state_t;

   localparam logic [1:0] ADDR_WIDTH  = 2'd0;
   localparam logic [1:0] ADDR_HEIGHT = 2'd1;
   localparam logic [1:0] ADDR_COUNT  = 2'd2;
   localparam logic [1:0] ADDR_DELAY  = 2'd3;

endpackage

// File: rtl/gif_frame_sequencer_prescaler.sv
// gif_tick_prescaler: divides clk down to a one-cycle delay tick.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   clear      : synchronous clear of the count (wins over enable)
//   enable     : count while high
//   tick       : high for one cycle when the count is at TICK_DIV-1 and enabled
module gif_tick_prescaler #(
   parameter int unsigned TICK_DIV = 50000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (enable) begin
         if (cnt == LAST) cnt <= '0;
         else             cnt <= cnt + CNT_W'(1);
      end
   end

   assign tick = enable && !clear && (cnt == LAST);

endmodule

// File: rtl/gif_frame_sequencer.sv
// gif_frame_sequencer: read-side owner of the image-details RAM.
// Loads width/height/frame count/frame delay, validates them, publishes
// them as a configuration and then paces frame requests to the decoder.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   start, stop           : start a load/playback run; abort to IDLE
//   mem_address/chipselect: RAM read address and select (registered)
//   mem_readdata          : RAM data, valid one cycle after the address
//   cfg_valid             : latched details are valid and in use
//   img_width/height      : detail words 0 and 1
//   frame_count/delay     : detail words 2 and 3 (delay in ticks)
//   frame_index           : index of current/requested frame
//   frame_req/frame_ack   : decoder request handshake
//   loop_done             : one-cycle pulse on wrap to frame 0
//   error                 : sticky invalid-details flag, cleared by start
module gif_frame_sequencer
   import gif_seq_pkg::*;
#(
   parameter int unsigned TICK_DIV = 50000,
   parameter int unsigned DLY_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   output logic [1:0]       mem_address,
   output logic             mem_chipselect,
   input  logic [15:0]      mem_readdata,
   output logic             cfg_valid,
   output logic [15:0]      img_width,
   output logic [15:0]      img_height,
   output logic [15:0]      frame_count,
   output logic [DLY_W-1:0] frame_delay,
   output logic [15:0]      frame_index,
   output logic             frame_req,
   input  logic             frame_ack,
   output logic             loop_done,
   output logic             error
);

   // A programmed delay of zero still waits one tick.
   function automatic logic [DLY_W-1:0] at_least_one(input logic [DLY_W-1:0] d);
      return (d == '0) ? DLY_W'(1) : d;
   endfunction

   seq_state_t       state;
   logic             rd_vld_p1;
   logic [1:0]       rd_addr_p1;
   logic [15:0]      last_idx;
   logic [DLY_W-1:0] dly_cnt;
   logic [DLY_W-1:0] dly_cnt_nxt;
   logic [DLY_W-1:0] dly_target;
   logic             tick;

   assign dly_cnt_nxt = dly_cnt + DLY_W'(1);
   assign dly_target  = at_least_one(frame_delay);

   gif_tick_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_prescaler (
      .clk    (clk),
      .reset  (reset),
      .clear  ((state != ST_WAIT) || stop),
      .enable (state == ST_WAIT),
      .tick   (tick)
   );

   // Stage p1: RAM data for the address presented last cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_vld_p1   <= 1'b0;
         rd_addr_p1  <= '0;
         img_width   <= '0;
         img_height  <= '0;
         frame_count <= '0;
         frame_delay <= '0;
      end else begin
         rd_vld_p1  <= mem_chipselect && (state == ST_LOAD) && !stop;
         rd_addr_p1 <= mem_address;
         if (rd_vld_p1 && (state == ST_LOAD) && !stop) begin
            case (rd_addr_p1)
               ADDR_WIDTH:  img_width   <= mem_readdata;
               ADDR_HEIGHT: img_height  <= mem_readdata;
               ADDR_COUNT:  frame_count <= mem_readdata;
               default:     frame_delay <= mem_readdata[DLY_W-1:0];
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= ST_IDLE;
         mem_address    <= '0;
         mem_chipselect <= 1'b0;
         cfg_valid      <= 1'b0;
         frame_index    <= '0;
         frame_req      <= 1'b0;
         loop_done      <= 1'b0;
         error          <= 1'b0;
         last_idx       <= '0;
         dly_cnt        <= '0;
      end else begin
         loop_done <= 1'b0;
         if (stop) begin
            // Details stay latched; only control and the index are cleared.
            state          <= ST_IDLE;
            mem_address    <= '0;
            mem_chipselect <= 1'b0;
            cfg_valid      <= 1'b0;
            frame_req      <= 1'b0;
            frame_index    <= '0;
            dly_cnt        <= '0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (start) begin
                     state          <= ST_LOAD;
                     error          <= 1'b0;
                     frame_index    <= '0;
                     cfg_valid      <= 1'b0;
                     mem_chipselect <= 1'b1;
                     mem_address    <= ADDR_WIDTH;
                  end
               end
               ST_LOAD: begin
                  // Addresses 0..3 go out on L0..L3; the last word lands on L4.
                  if (mem_chipselect) begin
                     if (mem_address == ADDR_DELAY) mem_chipselect <= 1'b0;
                     else                           mem_address    <= mem_address + 2'd1;
                  end
                  if (rd_vld_p1 && (rd_addr_p1 == ADDR_DELAY)) state <= ST_CHECK;
               end
               ST_CHECK: begin
                  if ((img_width == '0) || (img_height == '0) || (frame_count == '0)) begin
                     state <= ST_ERROR;
                     error <= 1'b1;
                  end else begin
                     state     <= ST_REQ;
                     cfg_valid <= 1'b1;
                     frame_req <= 1'b1;
                     last_idx  <= frame_count - 16'd1;
                     dly_cnt   <= '0;
                  end
               end
               ST_REQ: begin
                  if (frame_ack && frame_req) begin
                     frame_req <= 1'b0;
                     state     <= ST_WAIT;
                     if (frame_index == last_idx) begin
                        frame_index <= '0;
                        loop_done   <= 1'b1;
                     end else begin
                        frame_index <= frame_index + 16'd1;
                     end
                  end
               end
               ST_WAIT: begin
                  // Compare the incremented count so the next request leaves
                  // on the tick that completes the delay.
                  if (tick) begin
                     if (dly_cnt_nxt == dly_target) begin
                        dly_cnt   <= '0;
                        frame_req <= 1'b1;
                        state     <= ST_REQ;
                     end else begin
                        dly_cnt <= dly_cnt_nxt;
                     end
                  end
               end
               ST_ERROR: begin
                  state <= ST_ERROR;
               end
               default: begin
                  state <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_gif_frame_sequencer.sv
module tb_gif_frame_sequencer;

   localparam int TICK_DIV = 4;
   localparam int DLY_W    = 16;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic             stop;
   logic [1:0]       mem_address;
   logic             mem_chipselect;
   logic [15:0]      mem_readdata;
   logic             cfg_valid;
   logic [15:0]      img_width;
   logic [15:0]      img_height;
   logic [15:0]      frame_count;
   logic [DLY_W-1:0] frame_delay;
   logic [15:0]      frame_index;
   logic             frame_req;
   logic             frame_ack;
   logic             loop_done;
   logic             error;

   always #5 clk = ~clk;

   gif_frame_sequencer #(
      .TICK_DIV (TICK_DIV),
      .DLY_W    (DLY_W)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .stop           (stop),
      .mem_address    (mem_address),
      .mem_chipselect (mem_chipselect),
      .mem_readdata   (mem_readdata),
      .cfg_valid      (cfg_valid),
      .img_width      (img_width),
      .img_height     (img_height),
      .frame_count    (frame_count),
      .frame_delay    (frame_delay),
      .frame_index    (frame_index),
      .frame_req      (frame_req),
      .frame_ack      (frame_ack),
      .loop_done      (loop_done),
      .error          (error)
   );

   // RAM model: registered address, unregistered q
   logic [15:0] ram [4];
   logic [1:0]  ram_addr_q;
   always @(posedge clk) ram_addr_q <= mem_address;
   assign mem_readdata = ram[ram_addr_q];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int loop_cnt = 0;
   always @(posedge clk) if (loop_done) loop_cnt <= loop_cnt + 1;

   // Decoder model: acks once frame_req has been high for ack_lat cycles
   int ack_lat = 1;
   int req_age = 0;
   initial begin
      frame_ack = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (frame_req) begin
            frame_ack = (req_age >= ack_lat);
            req_age++;
         end else begin
            frame_ack = 1'b0;
            req_age   = 0;
         end
      end
   end

   typedef struct {
      int idx;
      int gap;
   } exp_t;
   exp_t sb[$];

   int n_cmp = 0;
   int n_bad = 0;
   int last_rise = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input int n);
      repeat (n) step();
   endtask

   // Wait for the next rising frame_req and score it against the queue head.
   task automatic wait_req(input int budget);
      bit   seen_low;
      bit   got;
      int   n;
      exp_t e;
      seen_low = !frame_req;
      got      = 1'b0;
      n        = 0;
      while (!got && n < budget) begin
         step();
         n++;
         if (!frame_req)    seen_low = 1'b1;
         else if (seen_low) got      = 1'b1;
      end
      check("req_seen", got, 1);
      if (got) begin
         check("sb_nonempty", sb.size() != 0, 1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("req_index", frame_index, e.idx);
            check("req_gap", cyc - last_rise, e.gap);
         end
         last_rise = cyc;
      end
   endtask

   // Preload RAM, pulse start and follow the LOAD address sequence.
   task automatic start_load(input logic [15:0] w, input logic [15:0] h,
                             input logic [15:0] c, input logic [15:0] d);
      ram[0] = w; ram[1] = h; ram[2] = c; ram[3] = d;
      start = 1'b1;
      step();
      start = 1'b0;
      last_rise = cyc;
      for (int k = 0; k < 4; k++) begin
         check("load_cs", mem_chipselect, 1);
         check("load_addr", mem_address, k);
         step();
      end
      check("load_cs_l4", mem_chipselect, 0);
   endtask

   task automatic do_stop();
      stop = 1'b1;
      step();
      stop = 1'b0;
      check("stop_req", frame_req, 0);
      check("stop_index", frame_index, 0);
      check("stop_cfg", cfg_valid, 0);
   endtask

   initial begin
      int lb;
      int reqs;
      reset = 1'b1;
      start = 1'b0;
      stop  = 1'b0;
      ram[0] = '0; ram[1] = '0; ram[2] = '0; ram[3] = '0;
      steps(3);
      check("rst_cfg", cfg_valid, 0);
      check("rst_req", frame_req, 0);
      check("rst_err", error, 0);
      check("rst_cs", mem_chipselect, 0);
      check("rst_index", frame_index, 0);
      check("rst_width", img_width, 0);
      reset = 1'b0;
      steps(2);

      // Playback {100,80,3,2}: frame 0 immediately, then 2 ticks + handshake
      sb.push_back('{0, 6});
      sb.push_back('{1, 10});
      sb.push_back('{2, 10});
      sb.push_back('{0, 10});
      sb.push_back('{1, 10});
      lb = loop_cnt;
      start_load(16'd100, 16'd80, 16'd3, 16'd2);
      wait_req(50);
      check("cfg_valid", cfg_valid, 1);
      check("width", img_width, 100);
      check("height", img_height, 80);
      check("count", frame_count, 3);
      check("delay", frame_delay, 2);
      wait_req(50);
      wait_req(50);
      steps(2);
      check("wrap_pulse", loop_done, 1);
      check("wrap_index", frame_index, 0);
      step();
      check("wrap_pulse_end", loop_done, 0);
      wait_req(50);
      check("loops_1", loop_cnt - lb, 1);
      wait_req(50);
      check("loops_1b", loop_cnt - lb, 1);

      // stop mid-WAIT
      steps(4);
      check("wait_req_low", frame_req, 0);
      check("wait_index", frame_index, 2);
      do_stop();
      check("stop_keep_width", img_width, 100);
      check("stop_keep_count", frame_count, 3);

      // Zero delay behaves as one tick
      sb.push_back('{0, 6});
      sb.push_back('{1, 6});
      sb.push_back('{2, 6});
      start_load(16'd100, 16'd80, 16'd3, 16'd0);
      wait_req(50);
      check("delay0", frame_delay, 0);
      wait_req(50);
      wait_req(50);
      do_stop();

      // start and stop together in IDLE: stop wins
      start = 1'b1;
      stop  = 1'b1;
      step();
      start = 1'b0;
      stop  = 1'b0;
      check("startstop_cs", mem_chipselect, 0);
      step();
      check("startstop_cs2", mem_chipselect, 0);

      // Decoder withholds ack for 20 cycles
      ack_lat = 20;
      sb.push_back('{0, 6});
      sb.push_back('{1, 29});
      start_load(16'd100, 16'd80, 16'd3, 16'd2);
      wait_req(50);
      steps(10);
      check("hold_req", frame_req, 1);
      check("hold_index", frame_index, 0);
      start = 1'b1;
      step();
      start = 1'b0;
      check("ign_start_req", frame_req, 1);
      check("ign_start_cs", mem_chipselect, 0);
      check("ign_start_index", frame_index, 0);
      wait_req(80);
      // stop mid-REQ
      steps(5);
      check("midreq_req", frame_req, 1);
      do_stop();
      ack_lat = 1;

      // Invalid details: height 0
      ram[0] = 16'd100; ram[1] = 16'd0; ram[2] = 16'd3; ram[3] = 16'd2;
      start = 1'b1;
      step();
      start = 1'b0;
      steps(6);
      check("err_set", error, 1);
      check("err_cfg", cfg_valid, 0);
      reqs = 0;
      repeat (10) begin
         step();
         if (frame_req) reqs++;
      end
      check("err_no_req", reqs, 0);
      start = 1'b1;
      step();
      start = 1'b0;
      check("err_ign_start", error, 1);
      check("err_ign_cs", mem_chipselect, 0);
      stop = 1'b1;
      step();
      stop = 1'b0;
      check("err_sticky", error, 1);
      ram[1] = 16'd80;
      start = 1'b1;
      step();
      start = 1'b0;
      check("err_cleared", error, 0);

      // Async reset in L2
      steps(2);
      check("l2_cs", mem_chipselect, 1);
      check("l2_addr", mem_address, 2);
      #2;
      reset = 1'b1;
      #1;
      check("areset_cs", mem_chipselect, 0);
      check("areset_addr", mem_address, 0);
      check("areset_width", img_width, 0);
      check("areset_count", frame_count, 0);
      check("areset_cfg", cfg_valid, 0);
      step();
      reset = 1'b0;
      step();
      check("areset_held_width", img_width, 0);

      // Reload after reset
      sb.push_back('{0, 6});
      sb.push_back('{1, 6});
      sb.push_back('{0, 6});
      lb = loop_cnt;
      start_load(16'd320, 16'd240, 16'd2, 16'd1);
      wait_req(50);
      check("re_width", img_width, 320);
      check("re_height", img_height, 240);
      check("re_count", frame_count, 2);
      check("re_delay", frame_delay, 1);
      check("re_cfg", cfg_valid, 1);
      wait_req(50);
      wait_req(50);
      check("re_loops", loop_cnt - lb, 1);
      do_stop();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
